// File: rtl/eth_nlp_if.sv
// eth_nlp_if: normal-link-pulse outputs toward the 10BASE-T transmit driver.
interface eth_nlp_if;
    logic        tx_nlp;
    logic        go;
    logic [31:0] c_out;
    modport master (output tx_nlp, go, c_out);
    modport slave  (input tx_nlp, go, c_out);
endinterface

// File: rtl/eth_nlp.sv
// eth_nlp: 10BASE-T normal link pulse generator; one NLP_WIDTH-cycle pulse at the end of every NLP_PERIOD.
module eth_nlp #(
    parameter longint unsigned NLP_PERIOD = 1600000,
    parameter longint unsigned NLP_WIDTH  = 10
) (
    input  logic clk,
    input  logic resetn,
    eth_nlp_if.master nlp
);
    localparam logic [31:0] LAST      = 32'(NLP_PERIOD - 1);
    localparam logic [31:0] RISE_PREV = 32'(NLP_PERIOD - NLP_WIDTH - 1);
    typedef enum logic {GAP = 1'b0, PULSE = 1'b1} state_t;
    state_t      state, state_nx;
    logic [31:0] cnt;
    logic        go_q;
    always_ff @(posedge clk or posedge resetn)
        if (resetn) state <= GAP;
        else        state <= state_nx;
    // go is decoded one cycle early so it leaves a flop aligned with the pulse start
    always_ff @(posedge clk or posedge resetn)
        if (resetn) begin
            cnt  <= '0;
            go_q <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? '0 : cnt + 32'd1;
            go_q <= (cnt == RISE_PREV);
        end
    always_comb
        state_nx = (state == GAP) ? ((cnt == RISE_PREV) ? PULSE : GAP)
                                  : ((cnt == LAST) ? GAP : PULSE);
    always_comb begin
        nlp.tx_nlp = (state == PULSE);
        nlp.go     = go_q;
        nlp.c_out  = cnt;
    end
endmodule

// File: tb/tb_eth_nlp.sv
// tb_eth_nlp: directed checks of eth_nlp at (20,3), (8,1) and default parameters.
module tb_eth_nlp;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    eth_nlp_if ifa ();
    eth_nlp_if ifb ();
    eth_nlp_if ifd ();
    eth_nlp #(.NLP_PERIOD(20), .NLP_WIDTH(3)) dut_a (.clk(clk), .resetn(resetn), .nlp(ifa));
    eth_nlp #(.NLP_PERIOD(8),  .NLP_WIDTH(1)) dut_b (.clk(clk), .resetn(resetn), .nlp(ifb));
    eth_nlp dut_d (.clk(clk), .resetn(resetn), .nlp(ifd));
    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [33:0] pack(input logic tx, input logic g, input logic [31:0] c);
        return {tx, g, c};
    endfunction
    task automatic check_all(input string tag, input int k);
        int ca, cb;
        ca = k % 20;
        cb = k % 8;
        chk({tag, "_a"}, pack(ifa.tx_nlp, ifa.go, ifa.c_out), pack(ca >= 17, ca == 17, 32'(ca)));
        chk({tag, "_b"}, pack(ifb.tx_nlp, ifb.go, ifb.c_out), pack(cb == 7, cb == 7, 32'(cb)));
        chk({tag, "_d"}, pack(ifd.tx_nlp, ifd.go, ifd.c_out), pack(1'b0, 1'b0, 32'(k)));
    endtask
    initial begin
        int n_go, last_go, tx_run;
        // long reset hold: everything stays at zero
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check_all("rst_hold", 0);
        end
        resetn = 1'b0;
        n_go = 0;
        last_go = -1;
        tx_run = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            check_all("run", k);
            if (ifa.go) begin
                if (last_go >= 0) chk("go_spacing", 34'(k - last_go), 34'd20);
                last_go = k;
                n_go++;
            end
            if (ifa.tx_nlp) tx_run++;
            else if (tx_run != 0) begin
                chk("tx_len", 34'(tx_run), 34'd3);
                tx_run = 0;
            end
        end
        chk("go_count", 34'(n_go), 34'd5);
        for (int k = 101; k <= 118; k++) begin
            @(negedge clk);
            check_all("pre_async", k);
        end
        chk("at18", pack(ifa.tx_nlp, ifa.go, ifa.c_out), pack(1'b1, 1'b0, 32'd18));
        #2 resetn = 1'b1;
        #1 chk("async_a", pack(ifa.tx_nlp, ifa.go, ifa.c_out), 34'd0);
        chk("async_b", pack(ifb.tx_nlp, ifb.go, ifb.c_out), 34'd0);
        chk("async_d", pack(ifd.tx_nlp, ifd.go, ifd.c_out), 34'd0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check_all("rst2", 0);
        end
        resetn = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            check_all("rerun", k);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_nlp.md
ETH_NLP -- requirements
Module: eth_nlp

Interface
REQ-001 Parameter NLP_PERIOD, default 1600000, shall set the pulse repetition period in clk cycles (16 ms at 100 MHz).
REQ-002 Parameter NLP_WIDTH, default 10, shall set the link-pulse width in clk cycles (100 ns at 100 MHz).
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  shall be the asynchronous, active-high reset (asserted when 1); the port keeps the codebase name resetn.
REQ-005 tx_nlp  output  1  shall be the normal-link-pulse output to the 10BASE-T transmit driver.
REQ-006 go  output  1  shall be a one-cycle strobe marking the first cycle of each link pulse.
REQ-007 c_out  output  32  shall expose the current period-counter value.

Function
REQ-008 Legal parameters shall satisfy 1 <= NLP_WIDTH < NLP_PERIOD <= 2^32; other values are unsupported.
REQ-009 The period counter shall be 32 bits wide and increment by 1 each clk cycle.
REQ-010 The counter shall wrap from NLP_PERIOD-1 to 0; it shall never hold a value >= NLP_PERIOD.
REQ-011 c_out shall equal the counter register, with no extra latency.
REQ-012 The FSM shall have two states: GAP (tx_nlp=0) and PULSE (tx_nlp=1).
REQ-013 GAP shall go to PULSE on the edge where the counter moves from NLP_PERIOD-NLP_WIDTH-1 to NLP_PERIOD-NLP_WIDTH.
REQ-014 PULSE shall go to GAP on the edge where the counter wraps from NLP_PERIOD-1 to 0.
REQ-015 tx_nlp shall be registered and shall be 1 exactly in the cycles where c_out >= NLP_PERIOD-NLP_WIDTH.
REQ-016 go shall be registered and shall be 1 exactly in the cycle where c_out == NLP_PERIOD-NLP_WIDTH; it shall be 0 otherwise.
REQ-017 Each period shall therefore contain exactly one go strobe and exactly NLP_WIDTH contiguous tx_nlp cycles.
REQ-018 The pulse shall end at the wrap, so the rising edge of tx_nlp repeats every NLP_PERIOD cycles.
REQ-019 When NLP_WIDTH = 1, go and tx_nlp shall be high in the same single cycle, c_out = NLP_PERIOD-1.
REQ-020 The outputs shall have no glitches: tx_nlp, go and c_out shall come directly from flops.

Reset
REQ-021 While resetn = 1, the block shall force: counter 0, state GAP, tx_nlp 0, go 0, c_out 0.
REQ-022 The reset shall act immediately, with no clock edge needed, including mid-pulse; tx_nlp shall drop to 0 at once.
REQ-023 After resetn falls to 0, the first rising clk edge shall set c_out to 1.
REQ-024 After reset release, the first go/tx_nlp rise shall occur when c_out first reaches NLP_PERIOD-NLP_WIDTH, i.e. NLP_PERIOD-NLP_WIDTH edges after release.

Verification (bench: 10 ns clock, reset held for 7 edges then released)
REQ-025 Use NLP_PERIOD=20 and NLP_WIDTH=3, reset then release -> c_out steps 0,1,...,19,0. The bench shall observe go=1 only at c_out=17, and tx_nlp=1 only at c_out=17,18,19.
REQ-026 Use the same parameters over 5 periods -> there shall be exactly 5 go strobes spaced 20 cycles apart, and each tx_nlp pulse shall last exactly 3 cycles.
REQ-027 Use the same parameters and assert resetn asynchronously at c_out=18 -> tx_nlp, go and c_out shall all be 0 before the next edge. After release, the first go shall occur 17 edges later.
REQ-028 Use NLP_PERIOD=8 and NLP_WIDTH=1 -> go and tx_nlp shall both be high in the single cycle at c_out=7, and low in all other cycles.
REQ-029 Use the default parameters -> the first go shall appear 1599990 edges after release, tx_nlp shall be high for 10 cycles (100 ns), and the repeat period shall be 16.000 ms.
REQ-030 Hold resetn=1 for 100 cycles -> all outputs shall stay 0 throughout.
